cv32e41s_rvfi_trace_fifo: RTL and testbench
===========================================

CV32E41S_RVFI_TRACE_FIFO -- requirements
Module: cv32e41s_rvfi_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, sets FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter SEQ_W, default 16, sets the width of the sequence and drop counters.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 enable_i  input  1  capture enable; records SHALL be taken only while it is 1.
REQ-006 rvfi_valid  input  1  one instruction retired this cycle.
REQ-007 rvfi_pc_rdata, rvfi_rd_wdata, rvfi_mem_addr[31:0], rvfi_mem_wdata[31:0]  input  32 each  retirement fields.
REQ-008 rvfi_rd_addr  input  5; rvfi_mem_rmask[3:0], rvfi_mem_wmask[3:0]  input  4 each.
REQ-009 rec_valid_o  output  1  head record available.
REQ-010 rec_ready_i  input  1  consumer accepts the head record.
REQ-011 rec_pc_o, rec_rd_wdata_o, rec_mem_addr_o, rec_mem_wdata_o (32); rec_rd_addr_o (5); rec_rmask_o, rec_wmask_o (4)  output  head record fields.
REQ-012 rec_seq_o  output  SEQ_W  sequence number of the head record.
REQ-013 rec_gap_o  output  1  one or more records were dropped immediately before the head record.
REQ-014 drop_cnt_o  output  SEQ_W  saturating count of dropped records.
REQ-015 full_o, empty_o  output  1 each  FIFO status.

Function
REQ-016 A capture event SHALL be rvfi_valid=1 and enable_i=1 in the same cycle.
REQ-017 Each capture event SHALL consume one value of a SEQ_W-bit sequence counter. The counter SHALL start at 0, increment by 1 per event, and wrap from all-ones to 0.
REQ-018 On a capture event, the block SHALL write the record into the FIFO if not full, or if full with a pop in the same cycle. The record is the RVFI fields, the current sequence value, and the pending-gap flag.
REQ-019 When an event is written, the pending-gap flag SHALL clear in the same cycle.
REQ-020 When an event finds the FIFO full with no pop, the record SHALL be dropped. The sequence counter SHALL still increment. The pending-gap flag SHALL set. drop_cnt_o SHALL increment and saturate at all-ones.
REQ-021 A pop SHALL occur when rec_valid_o=1 and rec_ready_i=1.
REQ-022 Outputs SHALL be registered with no fall-through. A record written in cycle N SHALL first appear on rec_* in cycle N+1.
REQ-023 rec_valid_o SHALL equal NOT empty_o. rec_* fields SHALL hold the head entry and stay stable while rec_valid_o=1 and rec_ready_i=0.
REQ-024 Push and pop in the same cycle SHALL leave the occupancy unchanged, whether the FIFO is empty, partial or full.
REQ-025 A push into an empty FIFO with rec_ready_i=1 SHALL NOT pop that same record in the same cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH. full_o SHALL assert at DEPTH entries; empty_o SHALL assert at 0 entries.
REQ-027 Cycles with rvfi_valid=1 and enable_i=0 SHALL change no state.
REQ-028 Any X on the rvfi_* fields of a captured record SHALL be stored as-is. The block SHALL NOT filter or decode records.

Reset
REQ-029 While rst_ni=0, the following SHALL hold regardless of clk_i:
- rec_valid_o=0, empty_o=1, full_o=0, rec_gap_o=0.
- rec_seq_o=0, drop_cnt_o=0; all other rec_* fields 0.
- Pointers, sequence counter and pending-gap flag at 0.
REQ-030 FIFO storage need not be reset. Reset asserted mid-operation SHALL discard all stored records.
REQ-031 The first capture after reset release SHALL carry seq=0 and gap=0.

Verification
REQ-032 Single record: reset, then one event with pc=0x0000_0080.
- Next cycle: rec_valid_o=1, rec_pc_o=0x80, rec_seq_o=0, rec_gap_o=0.
- One pop -> empty_o=1.
REQ-033 Overflow: DEPTH=8, rec_ready_i=0, 10 events.
- full_o=1 after the 8th event; drop_cnt_o=2.
- Drain all 8 (seq 0..7), then 1 more event -> rec_seq_o=10, rec_gap_o=1.
REQ-034 Full with concurrent pop: with the FIFO full, an event and a pop in the same cycle.
- No drop; occupancy stays 8; the popped record has seq 0.
REQ-035 Back-to-back streaming: an event every cycle with rec_ready_i=1 for 100 cycles.
- No drops; records arrive in order with seq 0..99, each one cycle after its capture.
REQ-036 Disable and wrap:
- enable_i=0 with 5 events -> no records, seq unchanged.
- Preload the sequence counter to 0xFFFF via 65535 events -> next records carry 0xFFFF then 0x0000.
REQ-037 Reset mid-stream: with 3 entries queued, pulse rst_ni low asynchronously.
- rec_valid_o drops immediately; the next event after release carries seq=0.

Source files
------------

// File: rtl/cv32e41s_rvfi_trace_fifo_if.sv
// cv32e41s_rvfi_trace_fifo_if: RVFI capture inputs and trace record outputs.
// The slave modport is the FIFO; the master modport is the surrounding system.
interface cv32e41s_rvfi_trace_fifo_if #(
    parameter int SEQ_W = 16
);
    logic             enable_i;
    logic             rvfi_valid;
    logic [31:0]      rvfi_pc_rdata;
    logic [31:0]      rvfi_rd_wdata;
    logic [31:0]      rvfi_mem_addr;
    logic [31:0]      rvfi_mem_wdata;
    logic [4:0]       rvfi_rd_addr;
    logic [3:0]       rvfi_mem_rmask;
    logic [3:0]       rvfi_mem_wmask;
    logic             rec_valid_o;
    logic             rec_ready_i;
    logic [31:0]      rec_pc_o;
    logic [31:0]      rec_rd_wdata_o;
    logic [31:0]      rec_mem_addr_o;
    logic [31:0]      rec_mem_wdata_o;
    logic [4:0]       rec_rd_addr_o;
    logic [3:0]       rec_rmask_o;
    logic [3:0]       rec_wmask_o;
    logic [SEQ_W-1:0] rec_seq_o;
    logic             rec_gap_o;
    logic [SEQ_W-1:0] drop_cnt_o;
    logic             full_o;
    logic             empty_o;

    modport master (
        output enable_i, rvfi_valid, rvfi_pc_rdata, rvfi_rd_wdata, rvfi_mem_addr,
               rvfi_mem_wdata, rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask, rec_ready_i,
        input  rec_valid_o, rec_pc_o, rec_rd_wdata_o, rec_mem_addr_o, rec_mem_wdata_o,
               rec_rd_addr_o, rec_rmask_o, rec_wmask_o, rec_seq_o, rec_gap_o,
               drop_cnt_o, full_o, empty_o
    );

    modport slave (
        input  enable_i, rvfi_valid, rvfi_pc_rdata, rvfi_rd_wdata, rvfi_mem_addr,
               rvfi_mem_wdata, rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask, rec_ready_i,
        output rec_valid_o, rec_pc_o, rec_rd_wdata_o, rec_mem_addr_o, rec_mem_wdata_o,
               rec_rd_addr_o, rec_rmask_o, rec_wmask_o, rec_seq_o, rec_gap_o,
               drop_cnt_o, full_o, empty_o
    );
endinterface

// File: rtl/cv32e41s_rvfi_trace_fifo.sv
// cv32e41s_rvfi_trace_fifo: RVFI retirement trace FIFO with sequence numbers,
// gap marking and a saturating drop counter.
module cv32e41s_rvfi_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    cv32e41s_rvfi_trace_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 4 * 32 + 5 + 4 + 4 + SEQ_W + 1;

    logic [RW-1:0]    mem [DEPTH];
    logic [RW-1:0]    head;
    logic [AW:0]      wptr, rptr;
    logic [SEQ_W-1:0] seq, drop_cnt;
    logic             gap_pend, capture, push, pop, full, empty;

    // pointers carry one extra lap bit so full and empty are distinguishable
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign capture = bus.rvfi_valid && bus.enable_i;
    assign pop     = !empty && bus.rec_ready_i;
    assign push    = capture && (!full || pop);
    assign head    = empty ? '0 : mem[rptr[AW-1:0]];

    assign {bus.rec_pc_o, bus.rec_rd_wdata_o, bus.rec_mem_addr_o, bus.rec_mem_wdata_o,
            bus.rec_rd_addr_o, bus.rec_rmask_o, bus.rec_wmask_o, bus.rec_seq_o, bus.rec_gap_o} = head;
    assign bus.rec_valid_o = !empty;
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.drop_cnt_o  = drop_cnt;

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wptr[AW-1:0]] <= {bus.rvfi_pc_rdata, bus.rvfi_rd_wdata, bus.rvfi_mem_addr,
                                  bus.rvfi_mem_wdata, bus.rvfi_rd_addr, bus.rvfi_mem_rmask,
                                  bus.rvfi_mem_wmask, seq, gap_pend};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr     <= '0;
            rptr     <= '0;
            seq      <= '0;
            gap_pend <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (capture) seq <= seq + 1'b1;
            if (push) gap_pend <= 1'b0;
            else if (capture) gap_pend <= 1'b1;
            if (capture && !push && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cv32e41s_rvfi_trace_fifo.sv
// tb_cv32e41s_rvfi_trace_fifo: directed scenarios for the RVFI trace FIFO.
module tb_cv32e41s_rvfi_trace_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cv32e41s_rvfi_trace_fifo_if #(.SEQ_W(16)) bus ();

    cv32e41s_rvfi_trace_fifo #(.DEPTH(8), .SEQ_W(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        bus.rvfi_valid     = v;
        bus.enable_i       = 1'b1;
        bus.rvfi_pc_rdata  = pc;
        bus.rvfi_rd_wdata  = ~pc;
        bus.rvfi_mem_addr  = pc + 32'h100;
        bus.rvfi_mem_wdata = pc ^ 32'h5a5a_5a5a;
        bus.rvfi_rd_addr   = pc[6:2];
        bus.rvfi_mem_rmask = 4'hf;
        bus.rvfi_mem_wmask = 4'h3;
    endtask

    task automatic evt(input logic [31:0] pc);
        drive(1'b1, pc);
        tick();
        bus.rvfi_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.rvfi_valid  = 1'b0;
        bus.enable_i    = 1'b0;
        bus.rec_ready_i = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0);
        bus.rec_ready_i = 1'b0;
        rst_n = 1'b0;
        tick();
        checks += 7;
        if (bus.rec_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rec_valid_o); end
        if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty_o); end
        if (bus.full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full_o); end
        if (bus.rec_gap_o !== 1'b0) begin failures++; $display("FAIL reset_gap got=%b exp=0", bus.rec_gap_o); end
        if (bus.rec_seq_o !== 16'h0) begin failures++; $display("FAIL reset_seq got=%h exp=0", bus.rec_seq_o); end
        if (bus.drop_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_drop got=%h exp=0", bus.drop_cnt_o); end
        if (bus.rec_pc_o !== 32'h0 || bus.rec_wmask_o !== 4'h0) begin failures++; $display("FAIL reset_fields got pc=%h wmask=%h exp=0", bus.rec_pc_o, bus.rec_wmask_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        evt(32'h0000_0080);
        checks += 6;
        if (bus.rec_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.rec_valid_o); end
        if (bus.rec_pc_o !== 32'h80) begin failures++; $display("FAIL single_pc got=%h exp=80", bus.rec_pc_o); end
        if (bus.rec_seq_o !== 16'h0) begin failures++; $display("FAIL single_seq got=%h exp=0", bus.rec_seq_o); end
        if (bus.rec_gap_o !== 1'b0) begin failures++; $display("FAIL single_gap got=%b exp=0", bus.rec_gap_o); end
        if (bus.rec_rd_wdata_o !== 32'hffff_ff7f || bus.rec_mem_addr_o !== 32'h180 || bus.rec_rd_addr_o !== 5'd0)
            begin failures++; $display("FAIL single_fields got rdw=%h addr=%h rd=%h", bus.rec_rd_wdata_o, bus.rec_mem_addr_o, bus.rec_rd_addr_o); end
        bus.rec_ready_i = 1'b1;
        tick();
        bus.rec_ready_i = 1'b0;
        if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%b exp=1", bus.empty_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            evt(32'h1000 + 32'(i) * 4);
            if (i == 7) begin
                checks++;
                if (bus.full_o !== 1'b1) begin failures++; $display("FAIL ovf_full8 got=%b exp=1", bus.full_o); end
            end
        end
        checks += 3;
        if (bus.drop_cnt_o !== 16'd2) begin failures++; $display("FAIL ovf_drop got=%0d exp=2", bus.drop_cnt_o); end
        if (bus.full_o !== 1'b1) begin failures++; $display("FAIL ovf_full10 got=%b exp=1", bus.full_o); end
        if (bus.rec_seq_o !== 16'd0 || bus.rec_pc_o !== 32'h1000) begin failures++; $display("FAIL ovf_hold got seq=%0d pc=%h exp seq=0 pc=1000", bus.rec_seq_o, bus.rec_pc_o); end
        bus.rec_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.rec_seq_o !== 16'(i) || bus.rec_pc_o !== 32'h1000 + 32'(i) * 4 || bus.rec_gap_o !== 1'b0)
                begin failures++; $display("FAIL ovf_drain%0d got seq=%0d pc=%h gap=%b", i, bus.rec_seq_o, bus.rec_pc_o, bus.rec_gap_o); end
            tick();
        end
        bus.rec_ready_i = 1'b0;
        checks++;
        if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%b exp=1", bus.empty_o); end
        evt(32'h2000);
        checks += 2;
        if (bus.rec_seq_o !== 16'd10) begin failures++; $display("FAIL ovf_after_seq got=%0d exp=10", bus.rec_seq_o); end
        if (bus.rec_gap_o !== 1'b1) begin failures++; $display("FAIL ovf_after_gap got=%b exp=1", bus.rec_gap_o); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 8; i++) evt(32'h3000 + 32'(i) * 4);
        drive(1'b1, 32'h4000);
        bus.rec_ready_i = 1'b1;
        checks++;
        if (bus.rec_seq_o !== 16'd0) begin failures++; $display("FAIL fpop_popped_seq got=%0d exp=0", bus.rec_seq_o); end
        tick();
        bus.rvfi_valid = 1'b0;
        bus.rec_ready_i = 1'b0;
        checks += 3;
        if (bus.full_o !== 1'b1) begin failures++; $display("FAIL fpop_full got=%b exp=1", bus.full_o); end
        if (bus.drop_cnt_o !== 16'd0) begin failures++; $display("FAIL fpop_drop got=%0d exp=0", bus.drop_cnt_o); end
        if (bus.rec_seq_o !== 16'd1) begin failures++; $display("FAIL fpop_head got=%0d exp=1", bus.rec_seq_o); end
        bus.rec_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (bus.rec_seq_o !== 16'(i) || bus.rec_valid_o !== 1'b1) begin failures++; $display("FAIL fpop_drain%0d got seq=%0d valid=%b", i, bus.rec_seq_o, bus.rec_valid_o); end
            tick();
        end
        bus.rec_ready_i = 1'b0;
        checks++;
        if (bus.rec_pc_o !== 32'h0 || bus.empty_o !== 1'b1) begin failures++; $display("FAIL fpop_end got pc=%h empty=%b exp pc=0 empty=1", bus.rec_pc_o, bus.empty_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.rec_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'(i) * 4);
            tick();
            checks++;
            if (bus.rec_valid_o !== 1'b1 || bus.rec_seq_o !== 16'(i) || bus.rec_pc_o !== 32'(i) * 4)
                begin failures++; $display("FAIL b2b_%0d got valid=%b seq=%0d pc=%h", i, bus.rec_valid_o, bus.rec_seq_o, bus.rec_pc_o); end
        end
        bus.rvfi_valid = 1'b0;
        tick();
        bus.rec_ready_i = 1'b0;
        checks += 2;
        if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", bus.empty_o); end
        if (bus.drop_cnt_o !== 16'd0) begin failures++; $display("FAIL b2b_drop got=%0d exp=0", bus.drop_cnt_o); end
    endtask

    task automatic test_disable_wrap();
        do_reset();
        drive(1'b1, 32'h5000);
        bus.enable_i = 1'b0;
        repeat (5) tick();
        checks += 2;
        if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL dis_empty got=%b exp=1", bus.empty_o); end
        if (bus.drop_cnt_o !== 16'd0) begin failures++; $display("FAIL dis_drop got=%0d exp=0", bus.drop_cnt_o); end
        bus.enable_i = 1'b1;
        bus.rec_ready_i = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (bus.rec_seq_o !== 16'd0) begin failures++; $display("FAIL dis_seq_unchanged got=%0d exp=0", bus.rec_seq_o); end
            end
        end
        bus.rvfi_valid = 1'b0;
        tick();
        bus.rec_ready_i = 1'b0;
        checks++;
        if (bus.empty_o !== 1'b1 || bus.drop_cnt_o !== 16'd0) begin failures++; $display("FAIL wrap_pre got empty=%b drop=%0d", bus.empty_o, bus.drop_cnt_o); end
        evt(32'h6000);
        evt(32'h6004);
        checks++;
        if (bus.rec_seq_o !== 16'hffff) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", bus.rec_seq_o); end
        bus.rec_ready_i = 1'b1;
        tick();
        bus.rec_ready_i = 1'b0;
        checks++;
        if (bus.rec_seq_o !== 16'h0000 || bus.rec_gap_o !== 1'b0 || bus.rec_pc_o !== 32'h6004)
            begin failures++; $display("FAIL wrap_0000 got seq=%h gap=%b pc=%h exp 0000/0/6004", bus.rec_seq_o, bus.rec_gap_o, bus.rec_pc_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) evt(32'h7000 + 32'(i) * 4);
        checks++;
        if (bus.rec_valid_o !== 1'b1) begin failures++; $display("FAIL mid_queued got=%b exp=1", bus.rec_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rec_valid_o !== 1'b0 || bus.empty_o !== 1'b1 || bus.rec_pc_o !== 32'h0)
            begin failures++; $display("FAIL mid_async got valid=%b empty=%b pc=%h", bus.rec_valid_o, bus.empty_o, bus.rec_pc_o); end
        tick();
        rst_n = 1'b1;
        evt(32'h7100);
        checks++;
        if (bus.rec_seq_o !== 16'd0 || bus.rec_gap_o !== 1'b0 || bus.rec_pc_o !== 32'h7100)
            begin failures++; $display("FAIL mid_after got seq=%0d gap=%b pc=%h exp 0/0/7100", bus.rec_seq_o, bus.rec_gap_o, bus.rec_pc_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_disable_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
